// File: rtl/dma_bus_arbiter_pkg.sv
// Shared widths, buffer-ring geometry and FSM encodings for the DMA bus arbiter.
// Used by both the default build and the DMA_STATS_EN build.
package dma_bus_arbiter_pkg;

   localparam int WORD_SIZE   = 16;
   localparam int BUF_SLOTS   = 4;
   localparam int MAX_PENDING = 3;
   localparam int STAT_W      = 16;

   localparam int PEND_W = $clog2(MAX_PENDING + 1);
   localparam int SLOT_W = (BUF_SLOTS > 1) ? $clog2(BUF_SLOTS) : 1;

   localparam logic [WORD_SIZE-1:0] DMA_BASE   = 16'h000b;
   localparam logic [WORD_SIZE-1:0] DMA_LENGTH = 16'd12;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_START   = 3'd1;
   localparam logic [2:0] ST_WAIT_BR = 3'd2;
   localparam logic [2:0] ST_HOLD    = 3'd3;
   localparam logic [2:0] ST_GRANT   = 3'd4;
   localparam logic [2:0] ST_RELEASE = 3'd5;

   // Slot stride equals the transfer length, so buffers pack back to back.
   function automatic logic [WORD_SIZE-1:0] slot_address(input logic [SLOT_W-1:0] slot);
      return DMA_BASE + WORD_SIZE'(slot) * DMA_LENGTH;
   endfunction

   function automatic logic [SLOT_W-1:0] next_slot(input logic [SLOT_W-1:0] slot);
      return (slot == SLOT_W'(BUF_SLOTS - 1)) ? '0 : slot + SLOT_W'(1);
   endfunction

endpackage

// File: rtl/dma_bus_arbiter_if.sv
// CPU/DMA handshake bundle between the arbiter (master) and its surroundings (slave).
// DMA_STATS_EN adds the xfer_count / stolen_cycles statistics outputs.
interface dma_bus_arbiter_if;
   import dma_bus_arbiter_pkg::*;

   logic                 ext_irq;
   logic                 cpu_mem_busy;
   logic                 br;
   logic                 dma_end;
   logic                 bg;
   logic                 begin_dma;
   logic [WORD_SIZE-1:0] target_address;
   logic [WORD_SIZE-1:0] length;
   logic                 cpu_bus_hold;
   logic                 dma_busy;
   logic [PEND_W-1:0]    pending_cnt;
   logic                 irq_overflow;
   logic                 dma_abort;
`ifdef DMA_STATS_EN
   logic [STAT_W-1:0]    xfer_count;
   logic [STAT_W-1:0]    stolen_cycles;

   modport master (
      input  ext_irq, cpu_mem_busy, br, dma_end,
      output bg, begin_dma, target_address, length, cpu_bus_hold, dma_busy,
             pending_cnt, irq_overflow, dma_abort, xfer_count, stolen_cycles
   );

   modport slave (
      output ext_irq, cpu_mem_busy, br, dma_end,
      input  bg, begin_dma, target_address, length, cpu_bus_hold, dma_busy,
             pending_cnt, irq_overflow, dma_abort, xfer_count, stolen_cycles
   );
`else
   modport master (
      input  ext_irq, cpu_mem_busy, br, dma_end,
      output bg, begin_dma, target_address, length, cpu_bus_hold, dma_busy,
             pending_cnt, irq_overflow, dma_abort
   );

   modport slave (
      output ext_irq, cpu_mem_busy, br, dma_end,
      input  bg, begin_dma, target_address, length, cpu_bus_hold, dma_busy,
             pending_cnt, irq_overflow, dma_abort
   );
`endif

endinterface

// File: rtl/dma_bus_arbiter_irq_queue.sv
// dma_irq_queue: external interrupt edge detect, saturating pending counter and
// drop (overflow) pulse. The arbiter FSM tells it when it is idle.
module dma_irq_queue
   import dma_bus_arbiter_pkg::*;
(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              ext_irq,
   input  logic              in_idle,
   output logic              irq_rise,
   output logic [PEND_W-1:0] pending_cnt,
   output logic              irq_overflow
);

   localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PENDING);

   logic              irq_q, irq_d;
   logic [PEND_W-1:0] pending_q, pending_d;
   logic              overflow_q, overflow_d;

   always_comb begin
      irq_d      = ext_irq;
      irq_rise   = ext_irq & ~irq_q;
      pending_d  = pending_q;
      overflow_d = 1'b0;
      if (in_idle) begin
         // Leaving IDLE pops one entry; a coincident edge refills it (net zero).
         if ((pending_q != '0) && !irq_rise) begin
            pending_d = pending_q - PEND_W'(1);
         end
      end else if (irq_rise) begin
         if (pending_q == PEND_MAX) begin
            overflow_d = 1'b1;
         end else begin
            pending_d = pending_q + PEND_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         irq_q      <= 1'b0;
         pending_q  <= '0;
         overflow_q <= 1'b0;
      end else begin
         irq_q      <= irq_d;
         pending_q  <= pending_d;
         overflow_q <= overflow_d;
      end
   end

   assign pending_cnt  = pending_q;
   assign irq_overflow = overflow_q;

endmodule

// File: rtl/dma_bus_arbiter.sv
// CPU/DMA bus arbiter: launches a DMA transfer per interrupt, grants the bus once the
// cache is quiet, and walks a ring of buffer slots. DMA_STATS_EN adds transfer statistics.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   IDLE    | no transfer; start on an irq edge or queued interrupt
//   START   | begin_dma pulse with target/length
//   WAIT_BR | waiting for the DMA engine to request the bus
//   HOLD    | datapath stalled, waiting for the cache access to drain
//   GRANT   | bus owned by DMA; latch dma_end, leave when br drops
//   RELEASE | bus returned; advance slot on success, else flag abort
module dma_bus_arbiter
   import dma_bus_arbiter_pkg::*;
(
   input  logic               clk,
   input  logic               reset_n,
   dma_bus_arbiter_if.master  bus
);

   logic [2:0]        state_q, state_d;
   logic [SLOT_W-1:0] slot_q, slot_d;
   logic              done_q, done_d;
   logic              abort_q, abort_d;

   logic              in_idle;
   logic              irq_rise;
   logic [PEND_W-1:0] pending_cnt;
   logic              irq_overflow;

   assign in_idle = (state_q == ST_IDLE);

   dma_irq_queue u_irq_queue (
      .clk          (clk),
      .reset_n      (reset_n),
      .ext_irq      (bus.ext_irq),
      .in_idle      (in_idle),
      .irq_rise     (irq_rise),
      .pending_cnt  (pending_cnt),
      .irq_overflow (irq_overflow)
   );

   always_comb begin
      state_d = state_q;
      slot_d  = slot_q;
      done_d  = done_q;
      abort_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (irq_rise || (pending_cnt != '0)) state_d = ST_START;
         end
         ST_START: begin
            state_d = ST_WAIT_BR;
         end
         ST_WAIT_BR: begin
            if (bus.br) state_d = ST_HOLD;
         end
         ST_HOLD: begin
            if (!bus.br) begin
               abort_d = 1'b1;
               state_d = ST_IDLE;
            end else if (!bus.cpu_mem_busy) begin
               state_d = ST_GRANT;
            end
         end
         ST_GRANT: begin
            if (bus.dma_end) done_d = 1'b1;
            if (!bus.br) state_d = ST_RELEASE;
         end
         ST_RELEASE: begin
            if (done_q) begin
               slot_d = next_slot(slot_q);
            end else begin
               abort_d = 1'b1;
            end
            done_d  = 1'b0;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         slot_q  <= '0;
         done_q  <= 1'b0;
         abort_q <= 1'b0;
      end else begin
         state_q <= state_d;
         slot_q  <= slot_d;
         done_q  <= done_d;
         abort_q <= abort_d;
      end
   end

   // Bus controls decode straight from state so reset drops them without a clock.
   assign bus.bg             = (state_q == ST_GRANT);
   assign bus.cpu_bus_hold   = (state_q == ST_HOLD) || (state_q == ST_GRANT);
   assign bus.begin_dma      = (state_q == ST_START);
   assign bus.dma_busy       = !in_idle;
   assign bus.target_address = slot_address(slot_q);
   assign bus.length         = DMA_LENGTH;
   assign bus.pending_cnt    = pending_cnt;
   assign bus.irq_overflow   = irq_overflow;
   assign bus.dma_abort      = abort_q;

`ifdef DMA_STATS_EN
   logic [STAT_W-1:0] xfer_q, xfer_d;
   logic [STAT_W-1:0] stolen_q, stolen_d;

   always_comb begin
      xfer_d   = xfer_q;
      stolen_d = stolen_q;
      if ((state_q == ST_RELEASE) && done_q) xfer_d = xfer_q + STAT_W'(1);
      if (state_q == ST_GRANT) stolen_d = stolen_q + STAT_W'(1);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         xfer_q   <= '0;
         stolen_q <= '0;
      end else begin
         xfer_q   <= xfer_d;
         stolen_q <= stolen_d;
      end
   end

   assign bus.xfer_count    = xfer_q;
   assign bus.stolen_cycles = stolen_q;
`endif

endmodule
